// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot-time instruction-memory loader:
// data widths and the two-bit FSM state encoding.
package imem_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write port.
// The image source uses master; the loader uses slave.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Big-endian byte-to-word assembler: the first byte of a group ends up in
// the most significant lane after four shifts.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0] byte_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (en) begin
      word     <= {word[WORD_W-BYTE_W-1:0], data};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign full = en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes them sequentially into
// instruction memory from address 0, and releases the CPU on a clean image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_loader_if.slave     bus,
  output logic             cpu_run,
  output logic [CNT_W-1:0] word_count,
  output logic             error
);

  logic [1:0]        state;
  logic              last_seen;
  logic              shift_en;
  logic              full;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  count_next;

  assign shift_en   = (state == LOAD) && bus.in_valid;
  assign count_next = word_count + CNT_W'(1);

  word_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .clear (state == WRITE),
    .data  (bus.in_data),
    .word  (word),
    .full  (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      last_seen  <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (full) begin
            state     <= WRITE;
            last_seen <= bus.in_last;
          end else if (shift_en && bus.in_last) begin
            // Image length is not a whole number of words.
            state <= ERR;
          end
        end
        WRITE: begin
          word_count <= count_next;
          if (last_seen)                            state <= RUN;
          else if (count_next == CNT_W'(MAX_WORDS)) state <= ERR;
          else                                      state <= LOAD;
        end
        default: state <= state;  // RUN and ERR hold until reset
      endcase
    end
  end

  // Every output decodes registered state only; nothing from in_* leaks through.
  assign bus.in_ready   = (state == LOAD);
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = WORD_W'(word_count) << 2;
  assign bus.imem_wdata = word;
  assign cpu_run        = (state == RUN);
  assign error          = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a scoreboard of expected memory writes is
// filled as images are streamed and drained by per-DUT write monitors.
module tb_imem_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus1 ();
  imem_loader_if bus2 ();
  logic        cpu_run1, error1, cpu_run2, error2;
  logic [10:0] word_count1;
  logic [2:0]  word_count2;

  imem_loader dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .cpu_run(cpu_run1), .word_count(word_count1), .error(error1)
  );

  imem_loader #(.MAX_WORDS(4), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .cpu_run(cpu_run2), .word_count(word_count2), .error(error2)
  );

  int  checks = 0;
  int  errors = 0;
  wr_t q1[$];
  wr_t q2[$];
  wr_t e1, e2;
  int  cyc = 0;
  int  first_acc = -1;
  int  accepts1 = 0, accepts2 = 0;
  int  we1 = 0, we2 = 0;
  int  low_cnt = 0;
  bit  count_low = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitors: each strobe must match the oldest pending expectation.
  always @(posedge clk) begin
    if (bus1.in_valid && bus1.in_ready) begin
      if (first_acc < 0) first_acc = cyc;
      accepts1++;
    end
    if (bus1.imem_we) begin
      we1++;
      check("we1_ready_low", 32'(bus1.in_ready), 32'd0);
      check("sb1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("wr1_addr", bus1.imem_addr, e1.addr);
        check("wr1_data", bus1.imem_wdata, e1.data);
      end
    end
    if (bus2.in_valid && bus2.in_ready) accepts2++;
    if (bus2.imem_we) begin
      we2++;
      check("sb2_pending", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        check("wr2_addr", bus2.imem_addr, e2.addr);
        check("wr2_data", bus2.imem_wdata, e2.data);
      end
    end
    cyc++;
  end

  always @(negedge clk)
    if (count_low && !bus1.in_ready && !cpu_run1 && !error1) low_cnt++;

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus1.in_ready : bus2.in_ready;
  endfunction

  // Offer one byte and return just after the edge that accepts it.
  task automatic send(input int sel, input logic [7:0] d, input logic last, input bit gap);
    int n;
    @(negedge clk);
    if (sel == 0) begin
      bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = last;
    end else begin
      bus2.in_valid = 1'b1; bus2.in_data = d; bus2.in_last = last;
    end
    n = 0;
    while (!rdy(sel) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (gap) begin
      @(negedge clk);
      if (sel == 0) bus1.in_valid = 1'b0; else bus2.in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus1.in_valid = 1'b0; bus1.in_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
  endtask

  task automatic do_reset();
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    first_acc = -1; accepts1 = 0; accepts2 = 0; we1 = 0; we2 = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!cpu_run1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("run_reached", 32'(cpu_run1), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus1.in_ready), 32'd1);
    check({tag, "_we"},    32'(bus1.imem_we), 32'd0);
    check({tag, "_addr"},  bus1.imem_addr, 32'd0);
    check({tag, "_wdata"}, bus1.imem_wdata, 32'd0);
    check({tag, "_run"},   32'(cpu_run1), 32'd0);
    check({tag, "_count"}, 32'(word_count1), 32'd0);
    check({tag, "_error"}, 32'(error1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] img [8];
  logic [7:0] b;
  logic [7:0] w [4];
  int         n;
  int         we_snap;

  initial begin
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

    // Reset state
    do_reset();
    check_reset_vals("rst");

    // Clean two-word image, valid held high
    q1.push_back('{32'h0, 32'h20080005});
    q1.push_back('{32'h4, 32'h0000000C});
    for (int i = 0; i < 8; i++) send(0, img[i], i == 7, 1'b0);
    idle();
    wait_run();
    check("run_latency", 32'(cyc - first_acc), 32'd10);
    check("a_count", 32'(word_count1), 32'd2);
    check("a_error", 32'(error1), 32'd0);
    check("a_writes", 32'(we1), 32'd2);
    check("a_sb_empty", 32'(q1.size()), 32'd0);

    // Same image with valid toggling every other cycle
    do_reset();
    low_cnt = 0;
    count_low = 1'b1;
    q1.push_back('{32'h0, 32'h20080005});
    q1.push_back('{32'h4, 32'h0000000C});
    for (int i = 0; i < 8; i++) send(0, img[i], i == 7, 1'b1);
    idle();
    wait_run();
    count_low = 1'b0;
    check("b_ready_low_cycles", 32'(low_cnt), 32'd2);
    check("b_count", 32'(word_count1), 32'd2);
    check("b_writes", 32'(we1), 32'd2);

    // Misaligned image: in_last on the sixth byte
    do_reset();
    q1.push_back('{32'h0, 32'h20080005});
    for (int i = 0; i < 6; i++) send(0, img[i], i == 5, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    check("c_error", 32'(error1), 32'd1);
    check("c_run", 32'(cpu_run1), 32'd0);
    check("c_ready", 32'(bus1.in_ready), 32'd0);
    check("c_count", 32'(word_count1), 32'd1);
    check("c_writes", 32'(we1), 32'd1);

    // Capacity overflow on the four-word instance
    do_reset();
    for (int wi = 0; wi < 4; wi++) begin
      for (int k = 0; k < 4; k++) w[k] = 8'((wi * 4 + k) * 7 + 3);
      q2.push_back('{32'(wi * 4), {w[0], w[1], w[2], w[3]}});
    end
    for (int i = 0; i < 16; i++) send(1, 8'(i * 7 + 3), 1'b0, 1'b0);
    // Keep offering byte 17 (and beyond); none may be accepted
    @(negedge clk);
    bus2.in_data = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("d_ready_low", 32'(bus2.in_ready), 32'd0);
      @(negedge clk);
    end
    idle();
    check("d_error", 32'(error2), 32'd1);
    check("d_run", 32'(cpu_run2), 32'd0);
    check("d_count", 32'(word_count2), 32'd4);
    check("d_writes", 32'(we2), 32'd4);
    check("d_accepts", 32'(accepts2), 32'd16);

    // Asynchronous reset after two words, then a one-word reload
    do_reset();
    for (int wi = 0; wi < 2; wi++) begin
      for (int k = 0; k < 4; k++) w[k] = 8'(8'hC0 + wi * 4 + k);
      q1.push_back('{32'(wi * 4), {w[0], w[1], w[2], w[3]}});
    end
    for (int i = 0; i < 8; i++) send(0, 8'(8'hC0 + i), 1'b0, 1'b0);
    idle();
    n = 0;
    while (word_count1 != 11'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("e_two_words", 32'(word_count1), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    first_acc = -1; we1 = 0;
    rst_n = 1'b1;
    q1.push_back('{32'h0, 32'h8C020004});
    b = 8'h8C; send(0, b, 1'b0, 1'b0);
    b = 8'h02; send(0, b, 1'b0, 1'b0);
    b = 8'h00; send(0, b, 1'b0, 1'b0);
    b = 8'h04; send(0, b, 1'b1, 1'b0);
    idle();
    wait_run();
    check("e_count", 32'(word_count1), 32'd1);
    check("e_writes", 32'(we1), 32'd1);

    // RUN is absorbing: offered bytes are ignored
    we_snap = we1;
    bus1.in_valid = 1'b1;
    bus1.in_data = 8'h55;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("f_ready", 32'(bus1.in_ready), 32'd0);
      check("f_run", 32'(cpu_run1), 32'd1);
    end
    idle();
    check("f_no_write", 32'(we1), 32'(we_snap));
    check("f_count", 32'(word_count1), 32'd1);
    check("f_sb_empty", 32'(q1.size() + q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a program image as a byte stream over a valid/ready handshake and packs bytes big-endian into 32-bit MIPS words. Each word is written sequentially into the instruction memory write port, starting at byte address 0. It holds the CPU halted (`cpu_run` = 0) until the image completes cleanly, then releases it permanently until the next reset.

## Interface
Parameters:
- `MAX_WORDS`, default 1024: instruction-memory capacity in words; the image may not exceed it.
- `CNT_W`, default 11: width of the word counter; must satisfy 2^CNT_W > `MAX_WORDS`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  byte offered on `in_data`.
- `in_data`  in  8  image byte.
- `in_last`  in  1  qualifies the final byte of the image; sampled with `in_valid`.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  32  byte address of the write; always word-aligned.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_run`  out  1  1 = CPU may fetch; 0 = CPU held (PC gated).
- `word_count`  out  CNT_W  number of words written so far.
- `error`  out  1  sticky load failure.

## Operation
- A byte transfers on any rising edge where `in_valid` & `in_ready` are both 1.
- Packing is big-endian: the first byte of each group lands in bits [31:24], the fourth in [7:0].
- The FSM has four states: `LOAD`, `WRITE`, `RUN`, `ERR`.
- `LOAD`:
  - `in_ready` = 1.
  - Each accepted byte shifts into the assembly register and increments `byte_idx` (0..3).
  - 4th byte accepted (`byte_idx` = 3): go to `WRITE`; latch `last_seen` = `in_last`.
  - `in_last` on byte 0, 1 or 2 (misaligned image): go to `ERR`; nothing is written.
- `WRITE`:
  - `in_ready` = 0, `imem_we` = 1.
  - `imem_addr` = `word_count` << 2, `imem_wdata` = assembled word.
  - Next edge: `word_count` += 1 and `byte_idx` = 0.
  - Exit: to `RUN` if `last_seen`; else to `ERR` if the new `word_count` == `MAX_WORDS`; else back to `LOAD`.
- `RUN`:
  - `cpu_run` = 1, `in_ready` = 0.
  - Absorbing; only reset leaves it. Bytes offered here are never accepted.
- `ERR`:
  - `error` = 1, `cpu_run` = 0, `in_ready` = 0.
  - Absorbing.
- Arithmetic: `imem_addr` is `word_count` zero-extended to 32 bits then shifted left by 2. The counter never wraps, because `ERR` is entered at `MAX_WORDS`.
- Reset mid-load:
  - All state clears and loading restarts at address 0.
  - Memory contents are not cleared; they are overwritten by the new image.

## Timing
- Reset values:
  - state `LOAD`, `in_ready` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_run` = 0, `word_count` = 0, `error` = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from `in_*` to any output.
- Throughput is 5 cycles per word when `in_valid` is held high: 4 accept cycles plus 1 `WRITE` cycle.
- `imem_we` is asserted for exactly one cycle per word.
- Memory captures the write on the edge that ends `WRITE`.
- `cpu_run` rises on the edge that ends the final `WRITE`. The CPU's first fetch at PC 0 sees the completed image.
- A stalled source (`in_valid` = 0) holds all state; there is no timeout.

## Structure
- Shared package holds:
  - state encoding constants (`LOAD`/`WRITE`/`RUN`/`ERR`, 2 bits);
  - `WORD_W` = 32;
  - `BYTE_W` = 8;
  - bytes-per-word = 4.
- Natural sub-module is `word_packer`. It contains:
  - the 32-bit shift register and the 2-bit `byte_idx`;
  - inputs: shift enable and clear;
  - outputs: `word` and `full` (`byte_idx` = 3 and enable).
- The FSM, word counter and memory-port registers live in `imem_loader`.
- The CPU gates its PC register with `cpu_run`.

## Test plan
- Stream bytes 20 08 00 05, 00 00 00 0C with `in_last` on the final byte:
  - writes 0x20080005 at addr 0 and 0x0000000C at addr 4;
  - `word_count` = 2;
  - `cpu_run` = 1 exactly 10 cycles after the first accept.
- Same image with `in_valid` toggling every other cycle: identical writes; `in_ready` = 0 exactly during each `WRITE`.
- `in_last` on the 6th byte: one write (word 0), then `ERR`; `error` = 1, `cpu_run` = 0, no second `imem_we`.
- With `MAX_WORDS` = 4, stream 20 bytes without `in_last`:
  - 4 writes at addrs 0..12, then `ERR` after the 4th;
  - `in_ready` stays 0, so the 17th byte is never accepted.
- Deassert `rst_n` asynchronously after 2 words:
  - outputs immediately take their reset values;
  - reload of a 1-word image writes addr 0 and reaches `RUN` with `word_count` = 1.
- After `RUN`, hold `in_valid` = 1 for 20 cycles: `in_ready` stays 0, no `imem_we`, `cpu_run` stays 1.
